// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronizes and debounces KEY[3:1] and SW[9:0]
// Optional key auto-repeat is built when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] key_raw,
  input  logic [9:0] sw_raw,
  output logic [2:0] key_level,
  output logic [2:0] key_press,
  output logic [9:0] sw_stable,
  output logic       sw_change,
  output logic [9:0] sw_toggled
);
  localparam int CW = 24;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("input_conditioner: parameter out of range");
  end

  logic [2:0]         key_s1, key_s2, key_pressed;
  logic [9:0]         sw_s1, sw_s2, sw_prev;
  logic [2:0][CW-1:0] key_cnt;
  logic [2:0]         key_flip;
  logic [2:0]         rpt_fire;
  logic [CW-1:0]      sw_cnt;
  logic               sw_moved, sw_accept;

  // Idle synchronizer state is "released" for the active-low keys and 0 for switches.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1      <= '1;
      key_s2      <= '1;
      key_pressed <= '0;
      sw_s1       <= '0;
      sw_s2       <= '0;
      sw_prev     <= '0;
    end else begin
      key_s1      <= key_raw;
      key_s2      <= key_s1;
      key_pressed <= ~key_s2;
      sw_s1       <= sw_raw;
      sw_s2       <= sw_s1;
      sw_prev     <= sw_s2;
    end
  end

  always_comb begin
    key_flip = '0;
    for (int i = 0; i < 3; i++)
      key_flip[i] = (key_pressed[i] != key_level[i]) && (key_cnt[i] == CNT_LAST);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_cnt   <= '0;
      key_level <= '0;
      key_press <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (key_pressed[i] == key_level[i] || key_flip[i])
          key_cnt[i] <= '0;
        else if (key_cnt[i] != CNT_MAX)
          key_cnt[i] <= key_cnt[i] + 1'b1;
      end
      key_level <= key_level ^ key_flip;
      key_press <= (key_flip & ~key_level) | rpt_fire;
    end
  end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [31:0] RPT_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  logic [2:0][31:0] rpt_cnt;
  logic [2:0]       rpt_armed;

  // A key that is about to be released never fires, so release cancels mid-interval.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 3; i++)
      rpt_fire[i] = key_level[i] && !key_flip[i] &&
                    (rpt_cnt[i] == (rpt_armed[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rpt_cnt   <= '0;
      rpt_armed <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!key_level[i] || key_flip[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  assign sw_moved  = (sw_s2 != sw_prev);
  assign sw_accept = !sw_moved && (sw_s2 != sw_stable) && (sw_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sw_cnt     <= '0;
      sw_stable  <= '0;
      sw_change  <= 1'b0;
      sw_toggled <= '0;
    end else begin
      if (sw_moved || sw_s2 == sw_stable || sw_accept)
        sw_cnt <= '0;
      else if (sw_cnt != CNT_MAX)
        sw_cnt <= sw_cnt + 1'b1;
      sw_change  <= sw_accept;
      sw_toggled <= sw_accept ? (sw_stable ^ sw_s2) : '0;
      if (sw_accept)
        sw_stable <= sw_s2;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - vector table, directed corners and random run vs reference model
module tb_input_conditioner;
  localparam int DB = 4, RD = 10, RP = 5, HMAX = 4096;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [2:0] key_raw;
  logic [9:0] sw_raw;
  logic [2:0] key_level, key_press;
  logic [9:0] sw_stable, sw_toggled;
  logic       sw_change;

  input_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .key_raw(key_raw), .sw_raw(sw_raw),
    .key_level(key_level), .key_press(key_press), .sw_stable(sw_stable),
    .sw_change(sw_change), .sw_toggled(sw_toggled)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [2:0] kh [HMAX];
  logic [9:0] sh [HMAX];
  logic [2:0] lvl_hist [HMAX];
  logic [2:0] m_level, m_press;
  logic [9:0] m_stable, m_tog;
  logic       m_chg;
  int         t_press [3];
  int         ev_key_t [$];
  logic [2:0] ev_key_v [$];
  int         ev_sw_t [$];
  logic [9:0] ev_sw_v [$], ev_sw_tog [$];

  typedef struct {
    logic [2:0] key;
    logic [9:0] sw;
    int         hold;
    logic [2:0] exp_level;
    logic [9:0] exp_stable;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pressed_at(input int c, input int i);
    logic [2:0] k;
    k = (c < 0) ? 3'b111 : kh[c];
    return !k[i];
  endfunction

  function automatic logic [9:0] sw_at(input int c);
    return (c < 0) ? 10'h000 : sh[c];
  endfunction

  // Reference: raw cycle c is seen by the outputs from edge c+7 onward; a key needs DB equal
  // samples, the switch vector needs DB+1 (the first sample restarts its shared counter).
  task automatic model_edge(input int e);
    logic v;
    logic [9:0] sv;
    bit same;
    int d;
    m_press = '0; m_chg = 1'b0; m_tog = '0;
    for (int i = 0; i < 3; i++) begin
      v = pressed_at(e - 4, i);
      same = 1;
      for (int c = e - DB - 3; c <= e - 4; c++) if (pressed_at(c, i) != v) same = 0;
      if (same && v != m_level[i]) begin
        m_level[i] = v;
        if (v) begin m_press[i] = 1'b1; t_press[i] = e; end
      end
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      else if (m_level[i]) begin
        d = e - t_press[i];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) m_press[i] = 1'b1;
      end
`endif
    end
    sv = sw_at(e - 3);
    same = 1;
    for (int c = e - DB - 3; c <= e - 3; c++) if (sw_at(c) != sv) same = 0;
    if (same && sv != m_stable) begin
      m_chg = 1'b1; m_tog = sv ^ m_stable; m_stable = sv;
    end
  endtask

  task automatic step(input logic [2:0] k, input logic [9:0] s);
    key_raw = k; sw_raw = s; kh[cyc] = k; sh[cyc] = s;
    @(posedge CLOCK_50); #1;
    cyc++;
    model_edge(cyc);
    lvl_hist[cyc] = key_level;
    if (key_press != 3'b000) begin ev_key_t.push_back(cyc); ev_key_v.push_back(key_press); end
    if (sw_change) begin ev_sw_t.push_back(cyc); ev_sw_v.push_back(sw_stable); ev_sw_tog.push_back(sw_toggled); end
    check($sformatf("model_cycle%0d", cyc),
          {key_level, key_press, sw_stable, sw_change, sw_toggled},
          {m_level, m_press, m_stable, m_chg, m_tog});
  endtask

  task automatic do_reset(input logic [2:0] k, input logic [9:0] s, input int hold);
    resetn = 1'b0; key_raw = k; sw_raw = s;
    #1 check("reset_async", {key_level, key_press, sw_stable, sw_change, sw_toggled}, 64'd0);
    for (int j = 0; j < hold; j++) begin
      @(posedge CLOCK_50); #1;
      check("reset_hold", {key_level, key_press, sw_stable, sw_change, sw_toggled}, 64'd0);
    end
    resetn = 1'b1; cyc = 0;
    m_level = '0; m_stable = '0;
    ev_key_t.delete(); ev_key_v.delete(); ev_sw_t.delete(); ev_sw_v.delete(); ev_sw_tog.delete();
  endtask

  task automatic check_times(input string name, input int exp_t[$], input int got_t[$]);
    check({name, "_count"}, got_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < got_t.size(); i++)
      check($sformatf("%s_t%0d", name, i), got_t[i], exp_t[i]);
  endtask

  initial begin
    vec_t vt [9];
    int   exp_t [$];
    int   win [$];
    logic [2:0] rk;
    logic [9:0] rs;

    resetn = 1'b1; key_raw = 3'b111; sw_raw = '0;
    @(posedge CLOCK_50); #1;

    // Reset held with every input active: all outputs stay 0.
    do_reset(3'b000, 10'h3FF, 4);

    // 3-cycle key glitch is ignored.
    for (int j = 0; j < 3; j++) step(3'b101, 10'h000);
    for (int j = 0; j < 12; j++) step(3'b111, 10'h000);
    check("glitch_press_count", ev_key_t.size(), 0);
    check("glitch_level", key_level, 3'b000);

    // Held key: level and one pulse at cycle 7, release drops level 7 cycles later.
    do_reset(3'b111, 10'h000, 2);
    for (int j = 0; j < 20; j++) step(3'b101, 10'h000);
    for (int j = 0; j < 15; j++) step(3'b111, 10'h000);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    exp_t = '{7, 17, 22};
`else
    exp_t = '{7};
`endif
    check_times("hold_press", exp_t, ev_key_t);
    if (ev_key_v.size() > 0) check("hold_press_bits", ev_key_v[0], 3'b010);
    check("hold_level_c6", lvl_hist[6], 3'b000);
    check("hold_level_c7", lvl_hist[7], 3'b010);
    check("release_level_c26", lvl_hist[26], 3'b010);
    check("release_level_c27", lvl_hist[27], 3'b000);

    // Switch change restarted by a second change 2 cycles later.
    do_reset(3'b111, 10'h000, 2);
    for (int j = 0; j < 2; j++) step(3'b111, 10'h001);
    for (int j = 0; j < 15; j++) step(3'b111, 10'h005);
    exp_t = '{9};
    check_times("sw_restart", exp_t, ev_sw_t);
    if (ev_sw_t.size() > 0) begin
      check("sw_restart_stable", ev_sw_v[0], 10'h005);
      check("sw_restart_toggled", ev_sw_tog[0], 10'h005);
    end

    // Reset mid-debounce: pending key discarded, held switches re-debounced once.
    do_reset(3'b111, 10'h000, 2);
    for (int j = 0; j < 2; j++) step(3'b101, 10'h005);
    #4 resetn = 1'b0;
    do_reset(3'b101, 10'h005, 2);
    for (int j = 0; j < 15; j++) step(3'b111, 10'h005);
    check("midreset_press_count", ev_key_t.size(), 0);
    exp_t = '{7};
    check_times("midreset_sw", exp_t, ev_sw_t);

    // Key held 30 cycles: pulse schedule within that window.
    do_reset(3'b111, 10'h000, 2);
    for (int j = 0; j < 30; j++) step(3'b110, 10'h000);
    for (int j = 0; j < 12; j++) step(3'b111, 10'h000);
    win.delete();
    foreach (ev_key_t[i]) if (ev_key_t[i] <= 30) win.push_back(ev_key_t[i]);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    exp_t = '{7, 17, 22, 27};
`else
    exp_t = '{7};
`endif
    check_times("repeat_window", exp_t, win);

    // Table of held input patterns with end-of-row state.
    vt[0] = '{3'b111, 10'h000, 10, 3'b000, 10'h000};
    vt[1] = '{3'b101, 10'h001, 10, 3'b010, 10'h001};
    vt[2] = '{3'b110, 10'h001,  3, 3'b010, 10'h001};
    vt[3] = '{3'b110, 10'h3FF, 10, 3'b001, 10'h3FF};
    vt[4] = '{3'b000, 10'h155,  2, 3'b001, 10'h3FF};
    vt[5] = '{3'b000, 10'h155,  8, 3'b111, 10'h155};
    vt[6] = '{3'b111, 10'h155,  6, 3'b111, 10'h155};
    vt[7] = '{3'b111, 10'h000,  1, 3'b000, 10'h155};
    vt[8] = '{3'b111, 10'h000,  9, 3'b000, 10'h000};
    do_reset(3'b111, 10'h000, 2);
    for (int r = 0; r < 9; r++) begin
      for (int j = 0; j < vt[r].hold; j++) step(vt[r].key, vt[r].sw);
      check($sformatf("table%0d_level", r), key_level, vt[r].exp_level);
      check($sformatf("table%0d_stable", r), sw_stable, vt[r].exp_stable);
    end

    // Random holds of 1..9 cycles against the reference model.
    do_reset(3'b111, 10'h000, 2);
    rk = 3'b111; rs = '0;
    for (int n = 0; n < 1500; ) begin
      int h;
      h = $urandom_range(1, 9);
      if ($urandom_range(0, 1) == 1) rk = 3'($urandom);
      case ($urandom_range(0, 3))
        0: rs = 10'($urandom);
        1: rs = rs ^ (10'd1 << $urandom_range(0, 9));
        default: ;
      endcase
      for (int j = 0; j < h; j++) step(rk, rs);
      n += h;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
